// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling, byte FIFO and CPU register port
module uart_rx_fifo #(
  parameter logic [7:0] DIV_RESET = 8'd25,
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       uart_rx,
  output logic       irq
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic [FIFO_AW:0] CNT_ONE = 1;
  state_t st_q, st_d;
  logic s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [1:0] vld_q, vld_d;
  logic [7:0] div_q, div_d, bc_q, bc_d, sh_q, sh_d, dout_q, dout_d;
  logic [3:0] tc_q, tc_d;
  logic [2:0] bi_q, bi_d;
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic ferr_q, ferr_d, ovr_q, ovr_d, ien_q, ien_d, irq_q, irq_d;
  logic [7:0] mem_q [1 << FIFO_AW];
  logic tick, samp, fall, push, ferr_set, wr_cpu, rd_cpu, full, avail, pop, flush, clr, push_ok;
  logic [7:0] status, rdata;
  // Synchronizer, baud tick and receive FSM; prev only tracks real line samples so a low line after reset is not a start edge
  always_comb begin
    s1_d = uart_rx;
    s2_d = s1_q;
    vld_d = (vld_q == 2'd2) ? vld_q : vld_q + 2'd1;
    prev_d = (vld_q == 2'd2) ? s2_q : 1'b0;
    fall = prev_q & ~s2_q;
    tick = bc_q == div_q;
    bc_d = (cs & we & (addr == 2'd2)) | tick ? 8'd0 : bc_q + 8'd1;
    samp = tick & (tc_q == 4'd7);
    st_d = st_q;
    tc_d = tick ? tc_q + 4'd1 : tc_q;
    bi_d = bi_q;
    sh_d = sh_q;
    push = 1'b0;
    ferr_set = 1'b0;
    case (st_q)
      IDLE: if (fall) begin
        st_d = START;
        tc_d = 4'd0;
      end
      START: if (samp) begin
        st_d = s2_q ? IDLE : DATA;
        bi_d = 3'd0;
      end
      DATA: if (samp) begin
        sh_d = {s2_q, sh_q[7:1]};
        bi_d = bi_q + 3'd1;
        st_d = (bi_q == 3'd7) ? STOP : DATA;
      end
      default: if (samp) begin
        st_d = IDLE;
        push = s2_q;
        ferr_set = ~s2_q;
      end
    endcase
  end
  // FIFO bookkeeping, CPU register access, flags and interrupt
  always_comb begin
    wr_cpu = cs & we;
    rd_cpu = cs & ~we;
    full = cnt_q[FIFO_AW];
    avail = cnt_q != '0;
    pop = rd_cpu & (addr == 2'd0) & avail;
    flush = wr_cpu & (addr == 2'd3) & din[2];
    clr = wr_cpu & (addr == 2'd3) & din[1];
    push_ok = push & ~flush & (~full | pop);
    wp_d = flush ? '0 : push_ok ? wp_q + PTR_ONE : wp_q;
    rp_d = flush ? '0 : pop ? rp_q + PTR_ONE : rp_q;
    cnt_d = flush ? '0 : (push_ok & ~pop) ? cnt_q + CNT_ONE : (pop & ~push_ok) ? cnt_q - CNT_ONE : cnt_q;
    ferr_d = (clr ? 1'b0 : ferr_q) | ferr_set;
    ovr_d = (clr ? 1'b0 : ovr_q) | (push & ~flush & full & ~pop);
    div_d = (wr_cpu & (addr == 2'd2)) ? din : div_q;
    ien_d = (wr_cpu & (addr == 2'd3)) ? din[0] : ien_q;
    status = {3'b000, st_q != IDLE, ferr_q, ovr_q, full, avail};
    rdata = (addr == 2'd0) ? (avail ? mem_q[rp_q] : 8'h00) :
            (addr == 2'd1) ? status :
            (addr == 2'd2) ? div_q : {7'b0, ien_q};
    dout_d = rd_cpu ? rdata : dout_q;
    irq_d = ien_q & (avail | ovr_q | ferr_q);
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= IDLE;
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b0;
      vld_q <= 2'd0;
      div_q <= DIV_RESET;
      bc_q <= 8'd0;
      tc_q <= 4'd0;
      bi_q <= 3'd0;
      sh_q <= 8'd0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
      ien_q <= 1'b0;
      dout_q <= 8'h00;
      irq_q <= 1'b0;
    end else begin
      st_q <= st_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      prev_q <= prev_d;
      vld_q <= vld_d;
      div_q <= div_d;
      bc_q <= bc_d;
      tc_q <= tc_d;
      bi_q <= bi_d;
      sh_q <= sh_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
      ien_q <= ien_d;
      dout_q <= dout_d;
      irq_q <= irq_d;
    end
  end
  // FIFO storage, written only when a received byte is accepted
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= sh_q;
  end
  assign dout = dout_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo with directed serial frames and register accesses
module tb_uart_rx_fifo;
  logic clk = 0, reset = 0, cs = 0, we = 0, rx = 1;
  logic [1:0] addr = 0;
  logic [7:0] din = 0;
  logic [7:0] dout;
  logic irq;
  typedef struct {string nm; logic [7:0] v;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int bt = 64;
  always #5 clk = ~clk;
  uart_rx_fifo dut (.clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout), .uart_rx(rx), .irq(irq));
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", nm, got, exp);
    end
  endtask
  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    exp_t x;
    x.nm = nm;
    x.v = e;
    sb.push_back(x);
    @(negedge clk);
    cs = 1; we = 0; addr = a;
    @(negedge clk);
    cs = 0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1; we = 1; addr = a; din = d;
    @(negedge clk);
    cs = 0; we = 0;
  endtask
  task automatic send(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (bt) @(negedge clk);
    end
    rx = 1;
  endtask
  always @(posedge clk) begin
    if (reset && cs && !we) begin
      @(negedge clk);
      if (sb.size() == 0) chk("sb_empty", dout, 8'hxx);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.nm, dout, e.v);
      end
    end
  end
  initial begin
    @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    reset = 1;
    repeat (3) @(negedge clk);
    rd(1, 8'h00, "st_rst");
    rd(2, 8'd25, "div_rst");
    rd(3, 8'h00, "ctl_rst");
    wr(2, 8'd3);
    rd(2, 8'd3, "div_wr");
    fork
      send(8'hA5, 1);
      begin
        repeat (200) @(negedge clk);
        rd(1, 8'h10, "st_busy");
      end
    join
    rd(1, 8'h01, "st_a5");
    rd(0, 8'hA5, "d_a5");
    rd(1, 8'h00, "st_a5_pop");
    rd(0, 8'h00, "d_empty");
    wr(0, 8'hFF);
    wr(1, 8'hFF);
    rd(1, 8'h00, "st_wr_ign");
    rx = 0;
    repeat (20) @(negedge clk);
    rx = 1;
    repeat (100) @(negedge clk);
    rd(1, 8'h00, "st_glitch");
    send(8'h3C, 0);
    rd(1, 8'h08, "st_ferr");
    wr(3, 8'h02);
    rd(1, 8'h00, "st_clr");
    for (int i = 0; i < 9; i++) send(8'(i), 1);
    rd(1, 8'h07, "st_full");
    for (int i = 0; i < 8; i++) rd(0, 8'(i), "d_fifo");
    rd(0, 8'h00, "d_empty2");
    rd(1, 8'h04, "st_ovr");
    wr(3, 8'h02);
    wr(3, 8'h01);
    rd(3, 8'h01, "ctl_ien");
    chk("irq_idle", {7'b0, irq}, 8'h00);
    send(8'h55, 1);
    chk("irq_55", {7'b0, irq}, 8'h01);
    rd(0, 8'h55, "d_55");
    chk("irq_lag", {7'b0, irq}, 8'h01);
    @(negedge clk);
    chk("irq_pop", {7'b0, irq}, 8'h00);
    send(8'h10, 1);
    send(8'h11, 1);
    send(8'h12, 1);
    chk("irq_q3", {7'b0, irq}, 8'h01);
    wr(3, 8'h05);
    rd(1, 8'h00, "st_flush");
    chk("irq_flush", {7'b0, irq}, 8'h00);
    rd(3, 8'h01, "ctl_rb");
    rd(0, 8'h00, "d_flushed");
    send(8'h77, 1);
    chk("irq_pre", {7'b0, irq}, 8'h01);
    rd(3, 8'h01, "ctl_pre");
    fork
      send(8'h0F, 1);
      begin
        repeat (352) @(negedge clk);
        reset = 0;
        #1;
        chk("rst_mid_dout", dout, 8'h00);
        chk("rst_mid_irq", {7'b0, irq}, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1;
        wr(2, 8'd3);
      end
    join
    repeat (100) @(negedge clk);
    rd(1, 8'h00, "st_abort");
    rd(3, 8'h00, "ctl_abort");
    rd(2, 8'd3, "div_abort");
    send(8'h81, 1);
    rd(1, 8'h01, "st_81");
    rd(0, 8'h81, "d_81");
    repeat (4) @(negedge clk);
    chk("sb_left", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
